serial_operand_serializer: RTL and testbench
============================================

# serial_operand_serializer

Parallel-to-serial front end for the bit-serial adder. Accepts two WIDTH-bit operands through a valid/ready handshake and presents them LSB first, one bit pair per cycle. Outputs framing strobes and a carry-clear pulse. Its serial outputs drive the adder's a/b inputs directly, and carry_clr is ORed into the adder's carry reset so every word starts with carry = 0.

## Interface
- WIDTH, 8: operand width in bits; legal range ≥ 2.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair present on in_a/in_b.
- in_ready  out  1  block can accept an operand pair this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- ser_a  out  1  current bit of A, registered.
- ser_b  out  1  current bit of B, registered.
- ser_valid  out  1  ser_a/ser_b carry a live bit this cycle.
- ser_first  out  1  current bit is bit 0 of a word.
- ser_last  out  1  current bit is bit WIDTH-1 of a word.
- carry_clr  out  1  combinational; high in the acceptance cycle; clears downstream carry at the following edge.

## Operation
- States: IDLE (no word in flight) and SHIFT (bits being emitted).
- Datapath:
  - two WIDTH-bit shift registers for A and B;
  - a bit counter of $clog2(WIDTH) bits, counting 0..WIDTH-1.
- Accept = in_valid & in_ready.
  - On accept, in_a/in_b are captured into the shift registers and the counter loads 0.
  - Later changes on in_a/in_b are ignored until the next accept.
- in_ready = !rst & (state==IDLE | (state==SHIFT & counter==WIDTH-1)).
  - This permits zero-bubble back-to-back words.
- carry_clr = accept.
- In SHIFT:
  - ser_a/ser_b = shift-register bit 0; ser_valid = 1.
  - ser_first = (counter==0); ser_last = (counter==WIDTH-1).
  - Each edge shifts both registers right by one and increments the counter.
- Transitions:
  - IDLE → SHIFT on accept.
  - SHIFT at counter==WIDTH-1: reload and stay in SHIFT on accept, else go to IDLE.
- In IDLE: ser_valid, ser_first and ser_last are 0; ser_a and ser_b are 0.
- There is no serial-side backpressure: once accepted, a word emits its WIDTH bits in WIDTH consecutive cycles.
- Reset:
  - state=IDLE, counter=0, shift registers=0.
  - ser_a, ser_b, ser_valid, ser_first, ser_last are 0 from the cycle after rst is sampled.
  - While rst is high: in_ready=0 and carry_clr=0, and in_valid is ignored.
- Reset mid-word: the partially emitted word is dropped, with no further bits and no ser_last for it.

## Timing
- Accept in cycle T:
  - bit k of the word appears in cycle T+1+k, for k = 0..WIDTH-1;
  - ser_first is high in T+1, ser_last is high in T+WIDTH.
- Latency from accept to first serial bit: 1 cycle.
- Throughput: one word per WIDTH cycles with in_valid held high; ser_valid is continuous, with no gap.
- Acceptance during the ser_last cycle (T+WIDTH):
  - that cycle's bit is still emitted correctly;
  - carry_clr clears the adder carry at the end of that cycle, so the adder's carry is 0 in the next word's bit-0 cycle.
- From IDLE, the earliest accept is the first cycle after rst deasserts.
- Simultaneous rst and in_valid: reset wins; nothing is accepted.

## Test plan
- Single word, WIDTH=8: accept A=8'h5A, B=8'h3C →
  - ser_a over 8 cycles = 0,1,0,1,1,0,1,0 and ser_b = 0,0,1,1,1,1,0,0;
  - downstream adder sum bits = 0,1,1,0,1,0,0,1 (0x96);
  - ser_first on cycle 1, ser_last on cycle 8.
- Back-to-back with in_valid held high: FF+01 then 01+01 →
  - 16 continuous ser_valid cycles, in_ready high only in cycles 8 and 16 of streaming (plus IDLE);
  - second word's adder sum = 0x02, proving carry_clr removed the carry left by FF+01.
- Idle gap: accept, wait 3 cycles after ser_last, accept again →
  - ser_valid low exactly during the 3 gap cycles;
  - the second word's bits start one cycle after its accept.
- Operand hold: change in_a/in_b every cycle during SHIFT → emitted bits match the values captured at accept only.
- Reset mid-word: assert rst in cycle 4 of a word →
  - ser_valid=0 from the next cycle, in_ready=0 during rst, in_ready=1 the cycle after rst drops;
  - the following word emits cleanly from bit 0.
- WIDTH=2: accept A=2'b10, B=2'b11 →
  - ser_a = 0,1 and ser_b = 1,1;
  - ser_first and ser_last in consecutive cycles;
  - in_ready high in the second bit cycle.

Source files
------------

// File: rtl/serial_operand_serializer_if.sv
// rtl/serial_operand_serializer_if.sv - operand-in / bit-serial-out bus for serial_operand_serializer
interface serial_operand_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             ser_a;
    logic             ser_b;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             carry_clr;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, ser_a, ser_b, ser_valid, ser_first, ser_last, carry_clr
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, ser_a, ser_b, ser_valid, ser_first, ser_last, carry_clr
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// rtl/serial_operand_serializer.sv - parallel-to-serial operand front end for the bit-serial adder
module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_operand_serializer_if.slave    bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;

    logic on_last;
    logic in_ready;
    logic accept;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        sh_a_q  <= sh_a_d;
        sh_b_q  <= sh_b_d;
    end

    // Accepting during the last bit reloads directly, giving back-to-back words with no bubble.
    always_comb begin
        on_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
        in_ready = !rst && ((state_q == IDLE) || on_last);
        accept   = bus.in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;

        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
            sh_a_d  = '0;
            sh_b_d  = '0;
        end else if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sh_a_d  = bus.in_a;
            sh_b_d  = bus.in_b;
        end else begin
            case (state_q)
                SHIFT: begin
                    sh_a_d = sh_a_q >> 1;
                    sh_b_d = sh_b_q >> 1;
                    if (on_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.carry_clr = accept;
    assign bus.ser_valid = (state_q == SHIFT);
    assign bus.ser_a     = (state_q == SHIFT) && sh_a_q[0];
    assign bus.ser_b     = (state_q == SHIFT) && sh_b_q[0];
    assign bus.ser_first = (state_q == SHIFT) && (cnt_q == '0);
    assign bus.ser_last  = on_last;
endmodule

// File: tb/tb_serial_operand_serializer.sv
// tb/tb_serial_operand_serializer.sv - scoreboard bench for serial_operand_serializer at WIDTH 8 and 2
module tb_serial_operand_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_operand_serializer_if #(.WIDTH(8)) if8 ();
    serial_operand_serializer_if #(.WIDTH(2)) if2 ();

    serial_operand_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_operand_serializer #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct packed {
        logic a;
        logic b;
        logic first;
        logic last;
    } bit_t;

    bit_t       q8[$];
    bit_t       q2[$];
    logic [7:0] w8[$];
    logic [1:0] w2[$];

    int   checks = 0;
    int   errors = 0;
    int   tmo_cnt = 0;
    logic started = 1'b0;
    logic done = 1'b0;
    logic got8 = 1'b0;
    logic got2 = 1'b0;
    logic exp_rdy8 = 1'b0;
    logic exp_rdy2 = 1'b0;

    logic       c8 = 1'b0;
    logic       c2 = 1'b0;
    logic [7:0] acc8 = '0;
    logic [1:0] acc2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push8(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < 8; k++) q8.push_back('{a: a[k], b: b[k], first: (k == 0), last: (k == 7)});
        w8.push_back(a + b);
    endtask

    task automatic push2(input logic [1:0] a, input logic [1:0] b);
        for (int k = 0; k < 2; k++) q2.push_back('{a: a[k], b: b[k], first: (k == 0), last: (k == 1)});
        w2.push_back(a + b);
    endtask

    // Advance one cycle and record whatever the model says was accepted at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        got8 = 1'b0;
        got2 = 1'b0;
        if (rst) begin
            q8.delete(); q2.delete(); w8.delete(); w2.delete();
        end else begin
            if (if8.in_valid && exp_rdy8) begin push8(if8.in_a, if8.in_b); got8 = 1'b1; end
            if (if2.in_valid && exp_rdy2) begin push2(if2.in_a, if2.in_b); got2 = 1'b1; end
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        if8.in_valid = 1'b1; if8.in_a = a; if8.in_b = b;
        do begin tick(); n++; end while (!got8 && n < 40);
        if (!got8) tmo_cnt++;
    endtask

    task automatic send2(input logic [1:0] a, input logic [1:0] b);
        int n;
        n = 0;
        if2.in_valid = 1'b1; if2.in_a = a; if2.in_b = b;
        do begin tick(); n++; end while (!got2 && n < 40);
        if (!got2) tmo_cnt++;
    endtask

    initial begin
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0;
        if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0;
        rst = 1'b1;
        if8.in_valid = 1'b1;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;

        send8(8'h5A, 8'h3C);
        if8.in_valid = 1'b0;
        repeat (10) tick();

        send8(8'hFF, 8'h01);
        send8(8'h01, 8'h01);
        if8.in_valid = 1'b0;
        repeat (10) tick();

        send8(8'h12, 8'h34);
        if8.in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if8.in_a = 8'($urandom); if8.in_b = 8'($urandom);
            tick();
        end
        send8(8'h9C, 8'h47);
        if8.in_valid = 1'b0;
        repeat (10) tick();

        send2(2'b10, 2'b11);
        if2.in_valid = 1'b0;
        repeat (4) tick();

        send8(8'hA5, 8'hC3);
        if8.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        send8(8'h0F, 8'hF1);
        if8.in_valid = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 500; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            if8.in_valid = ($urandom_range(0, 3) != 0);
            if8.in_a     = 8'($urandom);
            if8.in_b     = 8'($urandom);
            if2.in_valid = ($urandom_range(0, 3) != 0);
            if2.in_a     = 2'($urandom);
            if2.in_b     = 2'($urandom);
            tick();
        end
        rst = 1'b0;
        if8.in_valid = 1'b0;
        if2.in_valid = 1'b0;
        repeat (12) tick();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        bit_t e;
        logic s;
        if (started) begin
            exp_rdy8 = !rst && (q8.size() <= 1);
            chk("ready8", if8.in_ready, exp_rdy8);
            chk("carry_clr8", if8.carry_clr, exp_rdy8 && if8.in_valid);
            chk("valid8", if8.ser_valid, q8.size() != 0);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("bits8", {if8.ser_a, if8.ser_b, if8.ser_first, if8.ser_last}, e);
                s = if8.ser_a ^ if8.ser_b ^ c8;
                acc8 = {s, acc8[7:1]};
                if (e.last && w8.size() != 0) chk("sum8", acc8, w8.pop_front());
            end else begin
                chk("idle8", {if8.ser_a, if8.ser_b, if8.ser_first, if8.ser_last}, 0);
            end
            if (rst || if8.carry_clr) c8 = 1'b0;
            else if (if8.ser_valid) c8 = (if8.ser_a & if8.ser_b) | (if8.ser_a & c8) | (if8.ser_b & c8);

            exp_rdy2 = !rst && (q2.size() <= 1);
            chk("ready2", if2.in_ready, exp_rdy2);
            chk("carry_clr2", if2.carry_clr, exp_rdy2 && if2.in_valid);
            chk("valid2", if2.ser_valid, q2.size() != 0);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("bits2", {if2.ser_a, if2.ser_b, if2.ser_first, if2.ser_last}, e);
                s = if2.ser_a ^ if2.ser_b ^ c2;
                acc2 = {s, acc2[1]};
                if (e.last && w2.size() != 0) chk("sum2", acc2, w2.pop_front());
            end else begin
                chk("idle2", {if2.ser_a, if2.ser_b, if2.ser_first, if2.ser_last}, 0);
            end
            if (rst || if2.carry_clr) c2 = 1'b0;
            else if (if2.ser_valid) c2 = (if2.ser_a & if2.ser_b) | (if2.ser_a & c2) | (if2.ser_b & c2);
        end
        if (done) begin
            chk("drain8", q8.size(), 0);
            chk("drain2", q2.size(), 0);
            chk("send_timeouts", tmo_cnt, 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end
endmodule
